clk_period_meter: RTL

//  Measures the period of a slow, asynchronous square wave (sig_in), such as a

---
 rtl/clk_period_meter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of slow async sig_in in clk cycles; optional HIGH_TIME_EN macro adds high-time reporting
module clk_period_meter #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 100000000,
   parameter int CNT_W       = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic [CNT_W-1:0] high_time,
   output logic             timeout,
   output logic             locked
);
   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic                   valid_q, valid_d;
   logic                   timeout_q, timeout_d;
   logic                   locked_q, locked_d;
   logic                   s, rise;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d_q;

   // input synchronizer plus one-cycle delayed copy for edge detection
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_d  = s;
   end

   // synchronizer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         s_d_q  <= s_d_d;
      end
   end

   // measurement FSM: a rise in IDLE only arms; a rise in MEASURE reports cnt; cnt reaching TIMEOUT without a rise drops to IDLE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (rise) begin
            cnt_d     = ONE;
            timeout_d = 1'b0;
            state_d   = MEASURE;
         end
      end else if (rise) begin
         period_d = cnt_q;
         valid_d  = 1'b1;
         cnt_d    = ONE;
      end else if (cnt_q == TMO) begin
         state_d   = IDLE;
         timeout_d = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      locked_d = (state_d == MEASURE);
   end

   // FSM and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         locked_q  <= locked_d;
      end
   end

   assign period       = period_q;
   assign period_valid = valid_q;
   assign timeout      = timeout_q;
   assign locked       = locked_q;

`ifdef HIGH_TIME_EN
   logic             fall;
   logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
   logic             fall_seen_q, fall_seen_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;

   assign fall = ~s & s_d_q;

   // latch cnt at the falling edge; publish it alongside period (whole period if no fall was seen)
   always_comb begin
      hi_lat_d    = hi_lat_q;
      fall_seen_d = fall_seen_q;
      high_time_d = high_time_q;
      if (rise) begin
         fall_seen_d = 1'b0;
         if (state_q == MEASURE) high_time_d = fall_seen_q ? hi_lat_q : cnt_q;
      end else if (fall && state_q == MEASURE) begin
         hi_lat_d    = cnt_q;
         fall_seen_d = 1'b1;
      end
   end

   // high-time registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_lat_q    <= '0;
         fall_seen_q <= 1'b0;
         high_time_q <= '0;
      end else begin
         hi_lat_q    <= hi_lat_d;
         fall_seen_q <= fall_seen_d;
         high_time_q <= high_time_d;
      end
   end

   assign high_time = high_time_q;
`else
   assign high_time = '0;
`endif

endmodule
